// File: rtl/uart_rx_buffer.sv
// Receive-side word FIFO for a UART: edge-detected push/pop requests, registered status flags.
// Optional overflow event counter output ovf_cnt is enabled by defining UART_RXBUF_OVFCNT_EN.
module uart_rx_buffer #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = DEPTH - 2,
  parameter int FULL_MODE = 0
) (
  input  logic                     clk_50MHz,
  input  logic                     rst,
  input  logic                     wr_strobe,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_req,
  input  logic                     ovf_clr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
`ifdef UART_RXBUF_OVFCNT_EN
  ,
  output logic [7:0]               ovf_cnt
`endif
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C   = (AW+1)'(AFULL_LVL);
  localparam logic        OVERWRITE = (FULL_MODE != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              wr_strobe_q, rd_req_q;
  logic              armed;

  logic              push, pop, is_full, do_write, adv_rd, ovf_ev;
  logic [AW:0]       count_next;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    push       = armed & wr_strobe & ~wr_strobe_q;
    pop        = armed & rd_req & ~rd_req_q & (count != '0);
    is_full    = (count == DEPTH_C);
    // When full without a pop, the write either lands on the oldest slot or is dropped.
    do_write   = push & (~is_full | pop | OVERWRITE);
    adv_rd     = pop | (push & is_full & OVERWRITE);
    ovf_ev     = push & is_full & ~pop;
    count_next = count;
    if (do_write && !adv_rd)
      count_next = count + (AW+1)'(1);
    else if (adv_rd && !do_write)
      count_next = count - (AW+1)'(1);
  end

  // NOTE: the storage array has no reset; discarding words only needs pointers and count cleared.
  always_ff @(posedge clk_50MHz) begin
    if (do_write)
      mem[wr_ptr] <= wr_data;
  end

  // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      wr_strobe_q <= 1'b0;
      rd_req_q    <= 1'b0;
      armed       <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      // The first edge after release only samples, so a level already high is not an edge.
      armed       <= 1'b1;
      wr_strobe_q <= wr_strobe;
      rd_req_q    <= rd_req;
      if (do_write)
        wr_ptr <= wr_ptr + AW'(1);
      if (adv_rd)
        rd_ptr <= rd_ptr + AW'(1);
      if (pop)
        rd_data <= mem[rd_ptr];
      rd_valid    <= pop;
      count       <= count_next;
      empty       <= (count_next == '0);
      full        <= (count_next == DEPTH_C);
      almost_full <= (count_next >= AFULL_C);
      if (ovf_clr)
        overflow <= 1'b0;
      else if (ovf_ev)
        overflow <= 1'b1;
    end
  end

`ifdef UART_RXBUF_OVFCNT_EN
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst)
      ovf_cnt <= '0;
    else if (ovf_clr)
      ovf_cnt <= '0;
    else if (ovf_ev && ovf_cnt != 8'hFF)
      ovf_cnt <= ovf_cnt + 8'd1;
  end
`endif

endmodule
